// File: rtl/dma_xfer_engine.sv
// -----------------------------------------------------------------------------
// dma_xfer_engine
//
// Single-channel DMA transfer engine. On an accepted start it snapshots the
// configuration registers and moves LEN words through one valid/ready bus
// master port. Each word is one read from the source side followed by one
// write of that data to the destination side. Completion raises a sticky
// interrupt. An abort ends the transfer at the next word boundary.
//
// Ports
//   clk, reset      clock (rising edge), asynchronous active-high reset
//   start           1-cycle pulse, begin a transfer from cfg_* (ignored while busy)
//   abort           1-cycle pulse, stop after the word currently in progress
//   cfg_control     [1]=dir (0: io->mem, 1: mem->io), [2]=inc_io, [3]=inc_mem,
//                   [31:16]=LEN in words
//   cfg_io_addr     IO-side start address
//   cfg_mem_addr    memory-side start address
//   bus_addr        master address
//   bus_wr_en       1=write, 0=read
//   bus_valid       request valid
//   bus_ready       slave accept; read data valid on bus_rdata in the same cycle
//   bus_wdata       write data (the word just read)
//   bus_rdata       read data
//   busy            transfer in progress
//   intr            sticky completion flag, cleared by intr_clr
//   intr_clr        clears intr (a coincident completion wins)
//   aborted         last transfer ended by abort
//   remaining       words not yet written
// -----------------------------------------------------------------------------
module dma_xfer_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] cfg_control,
  input  logic [ADDR_WIDTH-1:0] cfg_io_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_mem_addr,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_wr_en,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  busy,
  output logic                  intr,
  input  logic                  intr_clr,
  output logic                  aborted,
  output logic [15:0]           remaining
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   io_addr_q, mem_addr_q;
  logic                    dir_q, inc_io_q, inc_mem_q;
  logic                    abort_pend_q;
  logic [15:0]             remaining_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    intr_q, aborted_q;

  logic                    start_ok;
  logic [15:0]             cfg_len;
  logic [ADDR_WIDTH-1:0]   src_addr, dst_addr;
  logic                    abort_now;

  // Control bits outside dir/inc/LEN are reserved and intentionally ignored.
  logic unused_cfg_bits;
  assign unused_cfg_bits = ^{cfg_control[15:4], cfg_control[0]};

  assign start_ok  = (state_q == ST_IDLE) && start;
  assign cfg_len   = cfg_control[31:16];
  assign src_addr  = dir_q ? mem_addr_q : io_addr_q;
  assign dst_addr  = dir_q ? io_addr_q  : mem_addr_q;
  // An abort arriving in the same cycle as the write handshake still ends the
  // transfer at this word boundary.
  assign abort_now = abort_pend_q | abort;

  // Next state and bus request. Request signals depend only on registered
  // state, so they stay stable until the slave accepts.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can leave
    // one unassigned and infer a latch.
    state_d   = state_q;
    bus_valid = 1'b0;
    bus_wr_en = 1'b0;
    bus_addr  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = (cfg_len != 16'd0) ? ST_RD : ST_DONE;
      end
      ST_RD: begin
        bus_valid = 1'b1;
        bus_addr  = src_addr;
        if (bus_ready) state_d = ST_WR;
      end
      ST_WR: begin
        bus_valid = 1'b1;
        bus_wr_en = 1'b1;
        bus_addr  = dst_addr;
        if (bus_ready) begin
          state_d = (remaining_q == 16'd1 || abort_now) ? ST_DONE : ST_RD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_addr_q    <= '0;
      mem_addr_q   <= '0;
      dir_q        <= 1'b0;
      inc_io_q     <= 1'b0;
      inc_mem_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      remaining_q  <= '0;
      wdata_q      <= '0;
      intr_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      // Configuration is captured only on an accepted start; later cfg_*
      // changes and starts while busy have no effect.
      if (start_ok) begin
        io_addr_q    <= cfg_io_addr;
        mem_addr_q   <= cfg_mem_addr;
        dir_q        <= cfg_control[1];
        inc_io_q     <= cfg_control[2];
        inc_mem_q    <= cfg_control[3];
        remaining_q  <= cfg_len;
        abort_pend_q <= 1'b0;
        aborted_q    <= 1'b0;
      end

      // Abort only latches while a transfer is moving words; the in-flight
      // request is never withdrawn.
      if ((state_q == ST_RD || state_q == ST_WR) && abort) begin
        abort_pend_q <= 1'b1;
      end

      if (state_q == ST_RD && bus_ready) begin
        wdata_q <= bus_rdata;
      end

      // Address arithmetic wraps modulo 2^ADDR_WIDTH.
      if (state_q == ST_WR && bus_ready) begin
        remaining_q <= remaining_q - 16'd1;
        if (inc_io_q)  io_addr_q  <= io_addr_q + ADDR_STEP;
        if (inc_mem_q) mem_addr_q <= mem_addr_q + ADDR_STEP;
      end

      // A completion in the same cycle as intr_clr leaves intr set.
      if (state_q == ST_DONE) begin
        intr_q    <= 1'b1;
        aborted_q <= abort_pend_q;
      end else if (intr_clr) begin
        intr_q <= 1'b0;
      end
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign bus_wdata = wdata_q;
  assign intr      = intr_q;
  assign aborted   = aborted_q;
  assign remaining = remaining_q;

endmodule
